// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between a display fetch
// path (high priority, never retried) and a host port (held until ack).
// A starvation counter forces a host grant after STARVE_MAX waiting cycles.
module mem_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic [DATA_W-1:0] o_vga_dat,
    output logic              o_vga_valid,
    output logic              o_vga_miss,
    input  logic              i_host_cs,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_dat,
    output logic [DATA_W-1:0] o_host_dat,
    output logic              o_host_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_dat,
    output logic              o_mem_we,
    output logic              o_mem_cs,
    input  logic [DATA_W-1:0] i_mem_dat
);

    typedef enum logic {
        H_IDLE,
        H_ACK
    } host_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VGA,
        TAG_HOST_RD,
        TAG_HOST_WR
    } tag_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    host_state_t host_state;
    tag_t        tag;
    logic [7:0]  starve_cnt;

    logic host_eligible;
    logic host_grant;
    logic vga_grant;

    // Grant decision; everything is held off while reset is asserted so a
    // write presented during reset never reaches memory.
    always_comb begin
        host_eligible = (host_state == H_IDLE) && i_host_cs;
        host_grant    = i_reset_n && host_eligible &&
                        (!i_vga_req || (starve_cnt == STARVE_LIM));
        vga_grant     = i_reset_n && i_vga_req && !host_grant;
    end

    // Memory port is driven by whichever requester holds the grant.
    always_comb begin
        o_mem_cs   = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_dat  = '0;
        o_vga_miss = 1'b0;
        if (host_grant) begin
            o_mem_cs   = 1'b1;
            o_mem_we   = i_host_we;
            o_mem_addr = i_host_addr;
            o_mem_dat  = i_host_dat;
            o_vga_miss = i_vga_req;
        end else if (vga_grant) begin
            o_mem_cs   = 1'b1;
            o_mem_addr = i_vga_addr;
        end
    end

    // Host FSM, in-flight tag and starvation counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            host_state <= H_IDLE;
            tag        <= TAG_NONE;
            starve_cnt <= '0;
        end else begin
            host_state <= host_grant ? H_ACK : H_IDLE;

            if (host_grant)
                tag <= i_host_we ? TAG_HOST_WR : TAG_HOST_RD;
            else if (vga_grant)
                tag <= TAG_VGA;
            else
                tag <= TAG_NONE;

            if (host_grant || !host_eligible)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Return path steered by the in-flight tag; data is zero unless valid.
    always_comb begin
        o_vga_valid = i_reset_n && (tag == TAG_VGA);
        o_host_ack  = i_reset_n && ((tag == TAG_HOST_RD) || (tag == TAG_HOST_WR));
        o_vga_dat   = o_vga_valid ? i_mem_dat : '0;
        o_host_dat  = (i_reset_n && (tag == TAG_HOST_RD)) ? i_mem_dat : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, checked
// against a cycle-level reference of the arbitration rules plus a scoreboard
// for the one-cycle-later read/ack responses.
module tb_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int SM = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_vga_req;
    logic [AW-1:0] i_vga_addr;
    logic [DW-1:0] o_vga_dat;
    logic          o_vga_valid;
    logic          o_vga_miss;
    logic          i_host_cs;
    logic          i_host_we;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_dat;
    logic [DW-1:0] o_host_dat;
    logic          o_host_ack;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_dat;
    logic          o_mem_we;
    logic          o_mem_cs;
    logic [DW-1:0] i_mem_dat;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SM)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_vga_req  (i_vga_req),
        .i_vga_addr (i_vga_addr),
        .o_vga_dat  (o_vga_dat),
        .o_vga_valid(o_vga_valid),
        .o_vga_miss (o_vga_miss),
        .i_host_cs  (i_host_cs),
        .i_host_we  (i_host_we),
        .i_host_addr(i_host_addr),
        .i_host_dat (i_host_dat),
        .o_host_dat (o_host_dat),
        .o_host_ack (o_host_ack),
        .o_mem_addr (o_mem_addr),
        .o_mem_dat  (o_mem_dat),
        .o_mem_we   (o_mem_we),
        .o_mem_cs   (o_mem_cs),
        .i_mem_dat  (i_mem_dat)
    );

    // Power-on contents of the memory, shared by the memory model and the reference.
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        int t;
        t = int'(a) * 7 + 3;
        if (a == 13'h0010) return 8'h41;
        return t[7:0];
    endfunction

    // Synchronous memory attached to the DUT.
    logic [7:0] mem [int];
    always @(posedge i_clk) begin
        if (o_mem_cs) begin
            if (o_mem_we)
                mem[int'(o_mem_addr)] = o_mem_dat;
            else
                i_mem_dat <= mem.exists(int'(o_mem_addr)) ? mem[int'(o_mem_addr)]
                                                          : init_byte(o_mem_addr);
        end
    end

    // Reference model state.
    logic [7:0] ref_mem [int];
    bit         m_ack;
    int         m_wait;
    bit         last_hg;

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    typedef struct {
        int         due;
        logic [7:0] dat;
    } exp_t;

    exp_t vq[$];
    exp_t hq[$];

    int cyc;
    int vectors;
    int miscompares;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // One clock of stimulus: drive, check the combinational grant, predict responses.
    task automatic step(input bit rst_n, input bit vga, input logic [AW-1:0] va,
                        input bit cs, input bit we, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd);
        bit            elig, hg, vg;
        logic [AW-1:0] ea;
        exp_t          e;
        @(negedge i_clk);
        cyc++;
        i_reset_n   = rst_n;
        i_vga_req   = vga;
        i_vga_addr  = va;
        i_host_cs   = cs;
        i_host_we   = we;
        i_host_addr = ha;
        i_host_dat  = hd;
        if (!rst_n) begin
            while (vq.size() > 0 && vq[0].due == cyc) void'(vq.pop_front());
            while (hq.size() > 0 && hq[0].due == cyc) void'(hq.pop_front());
        end

        elig = rst_n && !m_ack && cs;
        hg   = elig && (!vga || m_wait == SM);
        vg   = rst_n && vga && !hg;
        ea   = hg ? ha : (vg ? va : '0);

        #1;
        chk("mem_cs",   32'(o_mem_cs),   32'(hg || vg));
        chk("mem_we",   32'(o_mem_we),   32'(hg && we));
        chk("mem_addr", 32'(o_mem_addr), 32'(ea));
        chk("mem_dat",  32'(o_mem_dat),  hg ? 32'(hd) : 32'd0);
        chk("vga_miss", 32'(o_vga_miss), 32'(rst_n && vga && hg));

        if (vg) begin
            e.due = cyc + 1;
            e.dat = ref_rd(va);
            vq.push_back(e);
        end
        if (hg) begin
            e.due = cyc + 1;
            if (we) begin
                ref_mem[int'(ha)] = hd;
                e.dat = 8'h00;
            end else begin
                e.dat = ref_rd(ha);
            end
            hq.push_back(e);
        end

        if (!rst_n) begin
            m_ack  = 1'b0;
            m_wait = 0;
        end else begin
            m_ack  = hg;
            m_wait = hg ? 0 : (elig ? ((m_wait < SM) ? m_wait + 1 : SM) : 0);
        end
        last_hg = hg;
    endtask

    // Response monitor: pops expectations whenever a valid/ack appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            #2;
            if (o_vga_valid) begin
                if (vq.size() == 0 || vq[0].due != cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL vga_valid cycle %0d: got 1 expected 0", cyc);
                end else begin
                    e = vq.pop_front();
                    chk("vga_dat", 32'(o_vga_dat), 32'(e.dat));
                end
            end else begin
                chk("vga_dat_idle", 32'(o_vga_dat), 32'd0);
                if (vq.size() > 0 && vq[0].due == cyc) begin
                    void'(vq.pop_front());
                    vectors++;
                    miscompares++;
                    $display("FAIL vga_valid cycle %0d: got 0 expected 1", cyc);
                end
            end
            if (o_host_ack) begin
                if (hq.size() == 0 || hq[0].due != cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL host_ack cycle %0d: got 1 expected 0", cyc);
                end else begin
                    e = hq.pop_front();
                    chk("host_dat", 32'(o_host_dat), 32'(e.dat));
                end
            end else begin
                chk("host_dat_idle", 32'(o_host_dat), 32'd0);
                if (hq.size() > 0 && hq[0].due == cyc) begin
                    void'(hq.pop_front());
                    vectors++;
                    miscompares++;
                    $display("FAIL host_ack cycle %0d: got 0 expected 1", cyc);
                end
            end
        end
    end

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return 13'h1FF0 + AW'($urandom_range(0, 15));
    endfunction

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        bit            h_busy;
        bit            h_we;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_dat;
        bit            rst;
        bit            vga;
        int            vp;

        cyc = 0; vectors = 0; miscompares = 0;
        m_ack = 1'b0; m_wait = 0; last_hg = 1'b0;
        i_reset_n = 1'b0; i_vga_req = 1'b0; i_vga_addr = '0;
        i_host_cs = 1'b0; i_host_we = 1'b0; i_host_addr = '0; i_host_dat = '0;

        // Reset with a write and a fetch presented: nothing may reach memory.
        step(0, 1, 13'h0010, 1, 1, 13'h0010, 8'hEE);
        step(0, 1, 13'h0011, 1, 1, 13'h0011, 8'hEF);
        step(0, 0, '0, 0, 0, '0, '0);

        // Display fetch only.
        step(1, 1, 13'h0010, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Host write then read at the top address.
        step(1, 0, '0, 1, 1, 13'h1FFF, 8'hA5);
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 1, 0, 13'h1FFF, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Contention with an empty counter: display wins, host follows.
        step(1, 1, 13'h0003, 1, 0, 13'h0010, '0);
        step(1, 0, '0, 1, 0, 13'h0010, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Starvation: display held high, host read pending.
        for (int i = 0; i < 9; i++) step(1, 1, AW'(i), 1, 0, 13'h1FFF, '0);
        step(1, 1, 13'h0009, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Back-to-back host: cs held through the ack cycle.
        step(1, 0, '0, 1, 1, 13'h0020, 8'h5A);
        step(1, 0, '0, 1, 0, 13'h0020, '0);
        step(1, 0, '0, 1, 0, 13'h0020, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Reset the cycle after a host read grant.
        step(1, 0, '0, 1, 0, 13'h0020, '0);
        step(0, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);

        // Randomized traffic with varying display load.
        h_busy = 1'b0; h_we = 1'b0; h_addr = '0; h_dat = '0;
        for (int n = 0; n < 3000; n++) begin
            case ((n / 200) % 3)
                0:       vp = 20;
                1:       vp = 60;
                default: vp = 97;
            endcase
            rst = ($urandom_range(0, 99) != 0);
            if (!h_busy && $urandom_range(0, 99) < 40) begin
                h_busy = 1'b1;
                h_we   = ($urandom_range(0, 1) == 1);
                h_addr = pick_addr();
                h_dat  = DW'($urandom);
            end
            vga = ($urandom_range(0, 99) < vp);
            step(rst, vga, pick_addr(), h_busy, h_we, h_addr, h_dat);
            if (last_hg || !rst) h_busy = 1'b0;
        end

        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        @(negedge i_clk);
        #3;
        chk("pending_responses", 32'(vq.size() + hq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter STARVE_MAX, default 8, host wait-cycle limit before forced grant (range 1..255).
REQ-004 Clocking and reset SHALL be one clock and one reset: i_clk clocks the block; i_reset_n is a synchronous, active-low reset sampled on the i_clk rising edge.
REQ-005 i_clk  in  1  sole clock.
REQ-006 i_reset_n  in  1  synchronous active-low reset.
REQ-007 i_vga_req  in  1  display fetch request, single-cycle, read-only.
REQ-008 i_vga_addr  in  ADDR_W  display fetch address.
REQ-009 o_vga_dat  out  DATA_W  fetched byte.
REQ-010 o_vga_valid  out  1  o_vga_dat valid, one-cycle pulse.
REQ-011 o_vga_miss  out  1  display request refused this cycle, one-cycle pulse.
REQ-012 i_host_cs  in  1  host access request, held until ack.
REQ-013 i_host_we  in  1  host write enable, qualified by i_host_cs.
REQ-014 i_host_addr  in  ADDR_W  host address.
REQ-015 i_host_dat  in  DATA_W  host write data.
REQ-016 o_host_dat  out  DATA_W  host read data, valid with o_host_ack on reads.
REQ-017 o_host_ack  out  1  host access complete, one-cycle pulse.
REQ-018 o_mem_addr  out  ADDR_W  memory address.
REQ-019 o_mem_dat  out  DATA_W  memory write data.
REQ-020 o_mem_we  out  1  memory write enable.
REQ-021 o_mem_cs  out  1  memory chip select.
REQ-022 i_mem_dat  in  DATA_W  memory read data, valid one cycle after o_mem_cs read.

Function
REQ-023 Memory model: synchronous, captures o_mem_* on the i_clk edge; read data valid on i_mem_dat the following cycle.
REQ-024 o_mem_* SHALL be combinational from the current inputs and registered state; at most one requester granted per cycle.
REQ-025 Host FSM states: H_IDLE, H_ACK; H_IDLE -> H_ACK on host grant; H_ACK -> H_IDLE unconditionally.
REQ-026 Host eligible only in H_IDLE with i_host_cs=1; i_host_cs in H_ACK ignored (host drops cs after ack; max one host access per 2 cycles).
REQ-027 Priority: VGA wins if i_vga_req=1, unless host eligible and starve counter == STARVE_MAX, in which case host wins.
REQ-028 Granted requester drives o_mem_addr/o_mem_dat/o_mem_we (VGA: we=0, dat=0); o_mem_cs=1; no grant: all o_mem_* = 0.
REQ-029 Starve counter: increments (saturating at STARVE_MAX) each cycle host eligible but not granted; clears on host grant or when host not eligible.
REQ-030 o_vga_miss=1 in a cycle where i_vga_req=1 and host granted; refused request not retried.
REQ-031 VGA grant at cycle N -> o_vga_valid=1, o_vga_dat=i_mem_dat at N+1; latency exactly 1.
REQ-032 Host grant at cycle N -> o_host_ack=1 at N+1 (H_ACK); read: o_host_dat=i_mem_dat at N+1; write: o_host_dat=0.
REQ-033 o_vga_dat, o_host_dat SHALL be 0 whenever their valid/ack is 0.
REQ-034 Registered in-flight tag (none/VGA/host-read/host-write) selects the return path; one transaction in flight maximum.

Reset
REQ-035 While i_reset_n=0: state H_IDLE, starve counter 0, tag none; o_vga_valid, o_vga_miss, o_host_ack, o_mem_cs, o_mem_we = 0; all data/address outputs 0.
REQ-036 Reset mid-operation: in-flight access discarded; no o_vga_valid/o_host_ack in the first cycle after i_reset_n rises.
REQ-037 Write issued in the same cycle reset asserts SHALL NOT reach memory (o_mem_we forced 0 during reset).

Verification
REQ-038 VGA only: i_vga_req=1, addr 0x0010, mem[0x10]=0x41 -> o_mem_cs=1 same cycle; o_vga_valid=1, o_vga_dat=0x41 next cycle.
REQ-039 Host write then read: cs=1, we=1, addr 0x1FFF, dat 0xA5 -> ack one cycle later; read 0x1FFF -> o_host_dat=0xA5 with ack.
REQ-040 Contention: VGA and host request same cycle, counter 0 -> VGA granted, counter=1, no miss, host ack delayed.
REQ-041 Starvation: i_vga_req held high, host read pending, STARVE_MAX=8 -> host granted on 9th pending cycle, o_vga_miss=1 that cycle, ack next cycle, counter 0.
REQ-042 Back-to-back host: host holds cs through H_ACK -> no grant in H_ACK cycle, second access granted following cycle, exactly two acks.
REQ-043 Reset mid-read: host read granted, i_reset_n=0 next edge -> no o_host_ack, all outputs 0; after release, idle until new request.
